// File: rtl/fpu_pkg.sv
// Shared FPU definitions for the FP->integer conversion path.
// Contents:
//   - RISC-V rounding-mode encodings (RM_*)
//   - fflags bit positions inside the {NV,DZ,OF,UF,NX} vector (FFLAG_*)
//   - FCVT operation encodings: op[0] = signed result, op[1] = 64-bit result
//   - exponent classification passed from S1 to S2
//   - per-lane S1->S2 record (s1_lane_t)
//   - EXPBIAS(): IEEE exponent bias for a given exponent width
package fpu_pkg;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    localparam int FFLAG_NV = 4;
    localparam int FFLAG_DZ = 3;
    localparam int FFLAG_OF = 2;
    localparam int FFLAG_UF = 1;
    localparam int FFLAG_NX = 0;

    localparam logic [1:0] FCVT_W  = 2'b01;
    localparam logic [1:0] FCVT_WU = 2'b00;
    localparam logic [1:0] FCVT_L  = 2'b11;
    localparam logic [1:0] FCVT_LU = 2'b10;

    // FINITE: magnitude below 2^64, result comes from the shifted significand.
    // HUGE  : finite but |x| >= 2^64, out of range for every result width.
    // INFNAN: exponent field all ones.
    typedef enum logic [1:0] {
        EXPC_FINITE = 2'd0,
        EXPC_HUGE   = 2'd1,
        EXPC_INFNAN = 2'd2
    } exp_class_e;

    // Integer magnitude before rounding plus the round/sticky bits below it.
    typedef struct packed {
        logic        sign;
        logic        nan;
        logic        sel_lpath;
        exp_class_e  ecls;
        logic [63:0] mag;
        logic        rnd;
        logic        stk;
    } s1_lane_t;

    function automatic int EXPBIAS(input int expwidth);
        return (1 << (expwidth - 1)) - 1;
    endfunction

endpackage

// File: rtl/fp_to_int_lane_s1.sv
// Combinational first stage of the FP->integer converter, one lane.
// Decodes the operand, classifies the exponent and aligns the significand:
// large exponents shift left into an exact integer, small exponents shift
// right with sticky jam so S2 only needs to add a rounding increment.
// Ports:
//   a_i   in   EXPWIDTH+PRECISION   operand {sign, exponent, mantissa}
//   s1_o  out  s1_lane_t           sign, nan, path select, exp class,
//                                  integer magnitude, round and sticky bits
module fp_to_int_lane_s1
    import fpu_pkg::*;
#(
    parameter int EXPWIDTH  = 8,
    parameter int PRECISION = 24
) (
    input  logic [EXPWIDTH+PRECISION-1:0] a_i,
    output s1_lane_t                      s1_o
);

    localparam int FW   = EXPWIDTH + PRECISION;
    localparam int MW   = PRECISION - 1;
    localparam int RW   = PRECISION + 2;    // significand + round + sticky slot
    localparam int EW   = EXPWIDTH + 8;     // headroom for signed exponent math
    localparam int BIAS = EXPBIAS(EXPWIDTH);

    localparam logic signed [EW-1:0] BIAS_S   = EW'(BIAS);
    localparam logic signed [EW-1:0] UE_LPATH = EW'(PRECISION - 1);
    localparam logic signed [EW-1:0] UE_HUGE  = EW'(64);
    localparam logic        [EW-1:0] RSH_MAX  = EW'(RW);

    // Right shift; every bit shifted out is OR-ed into the result LSB.
    function automatic logic [RW-1:0] shift_right_jam(input logic [RW-1:0] x,
                                                      input logic [EW-1:0] sh);
        logic [RW-1:0] y;
        logic [RW-1:0] lost;
        y    = x >> sh;
        lost = x << (RSH_MAX - sh);
        y[0] = y[0] | (|lost);
        return y;
    endfunction

    logic                   sign;
    logic [EXPWIDTH-1:0]    exp_f;
    logic [MW-1:0]          man;
    logic [PRECISION-1:0]   sig;
    logic signed [EW-1:0]   ue;
    logic [EW-1:0]          lsh;
    logic [EW-1:0]          rsh;
    logic [EW-1:0]          rsh_c;
    logic [RW-1:0]          rj;
    logic                   is_max;
    logic                   lpath;

    assign sign  = a_i[FW-1];
    assign exp_f = a_i[FW-2 -: EXPWIDTH];
    assign man   = a_i[MW-1:0];
    // Subnormals get hidden bit 0; their exponent lands far below the
    // rounding point, so the whole significand collapses into sticky.
    assign sig   = {|exp_f, man};

    assign ue     = $signed({{(EW-EXPWIDTH){1'b0}}, exp_f}) - BIAS_S;
    assign is_max = &exp_f;
    assign lpath  = ue >= UE_LPATH;
    assign lsh    = ue - UE_LPATH;
    assign rsh    = UE_LPATH - ue;
    assign rsh_c  = (rsh > RSH_MAX) ? RSH_MAX : rsh;
    assign rj     = shift_right_jam({sig, 2'b00}, rsh_c);

    always_comb begin
        s1_o           = '0;
        s1_o.sign      = sign;
        s1_o.nan       = is_max && (|man);
        s1_o.sel_lpath = lpath;
        if (is_max)
            s1_o.ecls = EXPC_INFNAN;
        else if (ue >= UE_HUGE)
            s1_o.ecls = EXPC_HUGE;
        else
            s1_o.ecls = EXPC_FINITE;
        if (lpath) begin
            s1_o.mag = 64'(sig) << lsh;
        end else begin
            s1_o.mag = 64'(rj[RW-1:2]);
            s1_o.rnd = rj[1];
            s1_o.stk = rj[0];
        end
    end

endmodule

// File: rtl/fp_to_int_simt_pipe.sv
// Multi-lane, two-stage pipelined FP->integer converter (FCVT.W/WU/L/LU.S).
// S1: per-lane decode/align (fp_to_int_lane_s1). S2: round, range check,
// saturate and lane masking. Registers after S1 and after S2; full
// valid/ready backpressure, one beat per cycle, latency two cycles.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   in_valid_i     request valid          in_ready_o   request accepted
//   a_i            lane operands          mask_i       lane active
//   rm_i           rounding mode          op_i         [0] signed [1] 64-bit
//   tag_i          sideband               out_valid_o  result valid
//   out_ready_i    consumer ready         result_o     64 bits per lane
//   fflags_o       {NV,DZ,OF,UF,NX}/lane  fflags_or_o  OR over active lanes
//   mask_o, tag_o  mask_i / tag_i of the beat on the output
module fp_to_int_simt_pipe
    import fpu_pkg::*;
#(
    parameter int EXPWIDTH  = 8,
    parameter int PRECISION = 24,
    parameter int NUM_LANES = 4,
    parameter int TAG_WIDTH = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    in_valid_i,
    output logic                                    in_ready_o,
    input  logic [NUM_LANES*(EXPWIDTH+PRECISION)-1:0] a_i,
    input  logic [NUM_LANES-1:0]                    mask_i,
    input  logic [2:0]                              rm_i,
    input  logic [1:0]                              op_i,
    input  logic [TAG_WIDTH-1:0]                    tag_i,
    output logic                                    out_valid_o,
    input  logic                                    out_ready_i,
    output logic [NUM_LANES*64-1:0]                 result_o,
    output logic [NUM_LANES*5-1:0]                  fflags_o,
    output logic [4:0]                              fflags_or_o,
    output logic [NUM_LANES-1:0]                    mask_o,
    output logic [TAG_WIDTH-1:0]                    tag_o
);

    localparam int FW = EXPWIDTH + PRECISION;

    localparam logic [64:0] LIM31 = 65'd1 << 31;
    localparam logic [64:0] LIM32 = 65'd1 << 32;
    localparam logic [64:0] LIM63 = 65'd1 << 63;
    localparam logic [64:0] LIM64 = 65'd1 << 64;

    function automatic logic round_inc(input logic [2:0] rm, input logic sign,
                                       input logic lsb, input logic rnd, input logic stk);
        case (rm)
            RM_RNE:  return rnd && (stk || lsb);
            RM_RTZ:  return 1'b0;
            RM_RDN:  return sign && (rnd || stk);
            RM_RUP:  return !sign && (rnd || stk);
            RM_RMM:  return rnd;
            default: return 1'b0;
        endcase
    endfunction

    // Invalid-operation result; 32-bit results keep the upper word zero.
    function automatic logic [63:0] saturate(input logic [1:0] op, input logic neg);
        case ({neg, op})
            {1'b0, FCVT_W}:  return 64'h0000_0000_7FFF_FFFF;
            {1'b0, FCVT_WU}: return 64'h0000_0000_FFFF_FFFF;
            {1'b0, FCVT_L}:  return 64'h7FFF_FFFF_FFFF_FFFF;
            {1'b0, FCVT_LU}: return 64'hFFFF_FFFF_FFFF_FFFF;
            {1'b1, FCVT_W}:  return 64'h0000_0000_8000_0000;
            {1'b1, FCVT_L}:  return 64'h8000_0000_0000_0000;
            default:         return 64'd0;
        endcase
    endfunction

    function automatic void convert_lane(input s1_lane_t l, input logic [2:0] rm,
                                         input logic [1:0] op,
                                         output logic [63:0] res, output logic [4:0] flg);
        logic        inexact;
        logic        nv;
        logic [64:0] mag;
        logic [64:0] lim;
        inexact = !l.sel_lpath && (l.rnd || l.stk);
        // 65-bit sum so a rounding carry past 2^64 is still seen by the range check.
        mag = {1'b0, l.mag} + 65'(round_inc(rm, l.sign, l.mag[0], l.rnd, l.stk));
        if (op[0]) begin
            lim = op[1] ? LIM63 : LIM31;
            nv  = l.sign ? (mag > lim) : (mag >= lim);
        end else begin
            lim = op[1] ? LIM64 : LIM32;
            nv  = l.sign ? (mag != 65'd0) : (mag >= lim);
        end
        if (l.ecls != EXPC_FINITE)
            nv = 1'b1;
        if (nv) begin
            res = saturate(op, l.sign && !l.nan);
        end else begin
            res = l.sign ? (64'd0 - mag[63:0]) : mag[63:0];
            if (!op[1])
                res[63:32] = 32'd0;
        end
        flg           = 5'd0;
        flg[FFLAG_NV] = nv;
        flg[FFLAG_NX] = !nv && inexact;
    endfunction

    logic adv1;
    logic adv2;

    // ---- S1: decode and align ----
    s1_lane_t [NUM_LANES-1:0] s1_lane_w;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        fp_to_int_lane_s1 #(
            .EXPWIDTH  (EXPWIDTH),
            .PRECISION (PRECISION)
        ) u_s1 (
            .a_i  (a_i[k*FW +: FW]),
            .s1_o (s1_lane_w[k])
        );
    end

    logic                     s1_valid_q;
    logic                     s1_valid_d;
    s1_lane_t [NUM_LANES-1:0] s1_lane_q;
    logic [NUM_LANES-1:0]     s1_mask_q;
    logic [2:0]               s1_rm_q;
    logic [1:0]               s1_op_q;
    logic [TAG_WIDTH-1:0]     s1_tag_q;

    logic                     s2_valid_q;
    logic                     s2_valid_d;

    assign adv2       = !s2_valid_q || out_ready_i;
    assign adv1       = !s1_valid_q || adv2;
    assign in_ready_o = adv1;
    assign s1_valid_d = adv1 ? in_valid_i : s1_valid_q;
    assign s2_valid_d = adv2 ? s1_valid_q : s2_valid_q;

    always_ff @(posedge clk) begin
        if (rst)
            s1_valid_q <= 1'b0;
        else
            s1_valid_q <= s1_valid_d;
    end

    always_ff @(posedge clk) begin
        if (adv1 && in_valid_i) begin
            s1_lane_q <= s1_lane_w;
            s1_mask_q <= mask_i;
            s1_rm_q   <= rm_i;
            s1_op_q   <= op_i;
            s1_tag_q  <= tag_i;
        end
    end

    // ---- S2: round, range check, saturate, mask ----
    logic [NUM_LANES*64-1:0] result_d, result_q;
    logic [NUM_LANES*5-1:0]  fflags_d, fflags_q;
    logic [4:0]              fflags_or_d, fflags_or_q;
    logic [NUM_LANES-1:0]    mask_q;
    logic [TAG_WIDTH-1:0]    tag_q;
    logic [63:0]             lane_res;
    logic [4:0]              lane_flg;

    always_comb begin
        result_d    = '0;
        fflags_d    = '0;
        fflags_or_d = '0;
        lane_res    = '0;
        lane_flg    = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            convert_lane(s1_lane_q[k], s1_rm_q, s1_op_q, lane_res, lane_flg);
            if (s1_mask_q[k]) begin
                result_d[k*64 +: 64] = lane_res;
                fflags_d[k*5 +: 5]   = lane_flg;
                fflags_or_d          = fflags_or_d | lane_flg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q  <= 1'b0;
            result_q    <= '0;
            fflags_q    <= '0;
            fflags_or_q <= '0;
            mask_q      <= '0;
            tag_q       <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            if (adv2 && s1_valid_q) begin
                result_q    <= result_d;
                fflags_q    <= fflags_d;
                fflags_or_q <= fflags_or_d;
                mask_q      <= s1_mask_q;
                tag_q       <= s1_tag_q;
            end
        end
    end

    assign out_valid_o = s2_valid_q;
    assign result_o    = result_q;
    assign fflags_o    = fflags_q;
    assign fflags_or_o = fflags_or_q;
    assign mask_o      = mask_q;
    assign tag_o       = tag_q;

endmodule

// File: tb/tb_fp_to_int_simt_pipe.sv
module tb_fp_to_int_simt_pipe;

    localparam int NL = 4;
    localparam int TW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [NL*32-1:0]  a_i;
    logic [NL-1:0]     mask_i;
    logic [2:0]        rm_i;
    logic [1:0]        op_i;
    logic [TW-1:0]     tag_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [NL*64-1:0]  result_o;
    logic [NL*5-1:0]   fflags_o;
    logic [4:0]        fflags_or_o;
    logic [NL-1:0]     mask_o;
    logic [TW-1:0]     tag_o;

    fp_to_int_simt_pipe #(
        .EXPWIDTH (8), .PRECISION (24), .NUM_LANES (NL), .TAG_WIDTH (TW)
    ) dut (
        .clk (clk), .rst (rst),
        .in_valid_i (in_valid_i), .in_ready_o (in_ready_o),
        .a_i (a_i), .mask_i (mask_i), .rm_i (rm_i), .op_i (op_i), .tag_i (tag_i),
        .out_valid_o (out_valid_o), .out_ready_i (out_ready_i),
        .result_o (result_o), .fflags_o (fflags_o), .fflags_or_o (fflags_or_o),
        .mask_o (mask_o), .tag_o (tag_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [255:0] res;
        logic [19:0]  flg;
        logic [4:0]   flor;
        logic [3:0]   mask;
        logic [7:0]   tag;
    } exp_t;

    typedef struct packed {
        logic [127:0] a;
        logic [3:0]   mask;
        logic [2:0]   rm;
        logic [1:0]   op;
        exp_t         e;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic [127:0] a, input logic [3:0] m,
                                input logic [2:0] rm, input logic [1:0] op,
                                input logic [255:0] res, input logic [19:0] flg,
                                input logic [4:0] flor);
        vec_t v;
        v.a      = a;
        v.mask   = m;
        v.rm     = rm;
        v.op     = op;
        v.e.res  = res;
        v.e.flg  = flg;
        v.e.flor = flor;
        v.e.mask = m;
        v.e.tag  = 8'h00;
        return v;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Scoreboard monitor: every presented output is compared with the head
    // of the queue; the head is retired only on an actual handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got tag %0h expected no output", tag_o);
            end else begin
                e = exp_q[0];
                chk("result", 256'(result_o), 256'(e.res));
                chk("fflags", 256'(fflags_o), 256'(e.flg));
                chk("fflags_or", 256'(fflags_or_o), 256'(e.flor));
                chk("mask", 256'(mask_o), 256'(e.mask));
                chk("tag", 256'(tag_o), 256'(e.tag));
                if (out_ready_i)
                    void'(exp_q.pop_front());
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input vec_t v, input logic [7:0] tag);
        exp_t e;
        logic rdy;
        logic done;
        int   n;
        a_i        = v.a;
        mask_i     = v.mask;
        rm_i       = v.rm;
        op_i       = v.op;
        tag_i      = tag;
        in_valid_i = 1'b1;
        done       = 1'b0;
        n          = 0;
        while (!done) begin
            @(negedge clk);
            rdy = in_ready_o;
            @(posedge clk);
            #1;
            if (rdy) begin
                e     = v.e;
                e.tag = tag;
                exp_q.push_back(e);
                done  = 1'b1;
            end else begin
                n++;
                if (n > 50) begin
                    checks++;
                    errors++;
                    $display("FAIL issue_timeout: got no accept for tag %0h expected accept", tag);
                    done = 1'b1;
                end
            end
        end
        in_valid_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, 256'(exp_q.size()), 256'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid_i  = 1'b0;
        a_i         = '0;
        mask_i      = '0;
        rm_i        = '0;
        op_i        = '0;
        tag_i       = '0;
        out_ready_i = 1'b1;
        rst         = 1'b1;

        // W RNE: 1.5, 2^31, -2^31, -2.0
        vecs[0] = mk({32'hC0000000, 32'hCF000000, 32'h4F000000, 32'h3FC00000}, 4'hF, 3'd0, 2'b01,
                     {64'h00000000FFFFFFFE, 64'h0000000080000000, 64'h000000007FFFFFFF, 64'h2},
                     {5'h00, 5'h00, 5'h10, 5'h01}, 5'h11);
        // W RTZ: 1.5, 2.5, +0, +inf
        vecs[1] = mk({32'h7F800000, 32'h00000000, 32'h40200000, 32'h3FC00000}, 4'hF, 3'd1, 2'b01,
                     {64'h7FFFFFFF, 64'h0, 64'h2, 64'h1},
                     {5'h10, 5'h00, 5'h01, 5'h01}, 5'h11);
        // WU RTZ: -1.0, -0.25, 2^32, 2^31
        vecs[2] = mk({32'h4F000000, 32'h4F800000, 32'hBE800000, 32'hBF800000}, 4'hF, 3'd1, 2'b00,
                     {64'h80000000, 64'hFFFFFFFF, 64'h0, 64'h0},
                     {5'h00, 5'h10, 5'h01, 5'h10}, 5'h11);
        // L RNE mask 0101: NaN, (1.5 off), -2^63, (2^63 off)
        vecs[3] = mk({32'h5F000000, 32'hDF000000, 32'h3FC00000, 32'h7FC00000}, 4'b0101, 3'd0, 2'b11,
                     {64'h0, 64'h8000000000000000, 64'h0, 64'h7FFFFFFFFFFFFFFF},
                     {5'h00, 5'h00, 5'h00, 5'h10}, 5'h10);
        // LU RUP: 0.5, 2^64, -0.5, smallest subnormal
        vecs[4] = mk({32'h00000001, 32'hBF000000, 32'h5F800000, 32'h3F000000}, 4'hF, 3'd3, 2'b10,
                     {64'h1, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h1},
                     {5'h01, 5'h01, 5'h10, 5'h01}, 5'h11);
        // W RDN: -0.75, 2147483520, -(2^31+256), 0.99999994
        vecs[5] = mk({32'h3F7FFFFF, 32'hCF000001, 32'h4EFFFFFF, 32'hBF400000}, 4'hF, 3'd2, 2'b01,
                     {64'h0, 64'h80000000, 64'h7FFFFF80, 64'hFFFFFFFF},
                     {5'h01, 5'h10, 5'h00, 5'h01}, 5'h11);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 256'(out_valid_o), 256'd0);
        chk("rst_result", 256'(result_o), 256'd0);
        chk("rst_fflags", 256'(fflags_o), 256'd0);
        chk("rst_fflags_or", 256'(fflags_or_o), 256'd0);
        chk("rst_mask", 256'(mask_o), 256'd0);
        chk("rst_tag", 256'(tag_o), 256'd0);
        chk("rst_in_ready", 256'(in_ready_o), 256'd1);
        @(posedge clk);
        #1;

        // Back-to-back burst with a 3-cycle consumer stall.
        fork
            begin
                for (int i = 0; i < 6; i++)
                    issue(vecs[i], 8'(i + 1));
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                out_ready_i = 1'b0;
                @(negedge clk);
                chk("stall_in_ready", 256'(in_ready_o), 256'd0);
                repeat (3) @(posedge clk);
                #1;
                out_ready_i = 1'b1;
            end
        join
        drain("burst_drain");

        // Reset with two beats in flight.
        out_ready_i = 1'b0;
        issue(vecs[2], 8'h21);
        issue(vecs[3], 8'h22);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_out_valid", 256'(out_valid_o), 256'd0);
        chk("midrst_in_ready", 256'(in_ready_o), 256'd1);
        @(negedge clk);
        chk("midrst_no_emit", 256'(out_valid_o), 256'd0);
        @(posedge clk);
        #1;
        out_ready_i = 1'b1;

        // Fresh beat after reset: visible two cycles after acceptance.
        a_i        = vecs[4].a;
        mask_i     = vecs[4].mask;
        rm_i       = vecs[4].rm;
        op_i       = vecs[4].op;
        tag_i      = 8'h33;
        in_valid_i = 1'b1;
        @(negedge clk);
        chk("lat_in_ready", 256'(in_ready_o), 256'd1);
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        begin
            exp_t e;
            e     = vecs[4].e;
            e.tag = 8'h33;
            exp_q.push_back(e);
        end
        @(negedge clk);
        chk("lat_cycle1_valid", 256'(out_valid_o), 256'd0);
        @(posedge clk);
        @(negedge clk);
        chk("lat_cycle2_valid", 256'(out_valid_o), 256'd1);
        drain("final_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
